// File: rtl/ma_window_feeder.sv
// Window feeder for the 4-tap moving average: shifts accepted samples into a window and emits
// one registered beat (window before insertion + new sample). Optional macro: MA_WARMUP_GATE_EN.
module ma_window_feeder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned FillW = $clog2(DEPTH + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [WIDTH-1:0]         in_data_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [DEPTH*WIDTH-1:0]   out_window_o,
   output logic [WIDTH-1:0]         out_sample_o,
   output logic [FillW-1:0]         out_fill_o
);

   localparam logic [FillW-1:0] FillMax = FillW'(DEPTH);

   typedef enum logic [0:0] {StEmpty, StHold} state_e;

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       win_q [DEPTH];
   logic [WIDTH-1:0]       win_d [DEPTH];
   logic [FillW-1:0]       fill_q, fill_d;
   logic [DEPTH*WIDTH-1:0] out_window_q, out_window_d;
   logic [WIDTH-1:0]       out_sample_q, out_sample_d;
   logic [FillW-1:0]       out_fill_q, out_fill_d;

   logic                   accept;
   logic                   beat;
   logic [FillW-1:0]       fill_inc;
   logic [DEPTH*WIDTH-1:0] win_flat;

   assign out_valid_o  = (state_q == StHold);
   assign out_window_o = out_window_q;
   assign out_sample_o = out_sample_q;
   assign out_fill_o   = out_fill_q;

   assign in_ready_o = !rst_i && !clear_i && (!out_valid_o || out_ready_i);
   assign accept     = in_valid_i && in_ready_o;
   assign fill_inc   = (fill_q == FillMax) ? fill_q : fill_q + FillW'(1);

`ifdef MA_WARMUP_GATE_EN
   // Warm-up samples only shift the window; the first beat carries a full window.
   assign beat = accept && (fill_inc == FillMax);
`else
   assign beat = accept;
`endif

   // Element 0 (newest) lands in the MSBs.
   always_comb begin
      win_flat = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         win_flat[(int'(DEPTH) - 1 - i) * int'(WIDTH) +: WIDTH] = win_q[i];
      end
   end

   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      fill_d       = fill_q;
      out_window_d = out_window_q;
      out_sample_d = out_sample_q;
      out_fill_d   = out_fill_q;

      if (clear_i) begin
         state_d      = StEmpty;
         fill_d       = '0;
         out_window_d = '0;
         out_sample_d = '0;
         out_fill_d   = '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            win_d[i] = '0;
         end
      end else begin
         if (accept) begin
            win_d[0] = in_data_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
               win_d[i] = win_q[i-1];
            end
            fill_d = fill_inc;
         end
         unique case (state_q)
            StEmpty: begin
               if (beat) begin
                  state_d = StHold;
               end
            end
            StHold: begin
               if (!beat && out_ready_i) begin
                  state_d = StEmpty;
               end
            end
            default: state_d = StEmpty;
         endcase
         if (beat) begin
            out_window_d = win_flat;
            out_sample_d = in_data_i;
            out_fill_d   = fill_inc;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StEmpty;
         fill_q       <= '0;
         out_window_q <= '0;
         out_sample_q <= '0;
         out_fill_q   <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            win_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         fill_q       <= fill_d;
         out_window_q <= out_window_d;
         out_sample_q <= out_sample_d;
         out_fill_q   <= out_fill_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            win_q[i] <= win_d[i];
         end
      end
   end

endmodule

// File: tb/tb_ma_window_feeder.sv
// Directed bench for ma_window_feeder: a window model pushes expected beats into a queue on
// accept; beats are compared while out_valid is high and popped on completion.
module tb_ma_window_feeder;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned FW    = $clog2(DEPTH + 1);

   typedef struct {
      logic [DEPTH*WIDTH-1:0] win;
      logic [WIDTH-1:0]       smp;
      logic [FW-1:0]          fill;
   } beat_t;

   logic                   clk = 1'b0;
   logic                   rst, clear, in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0]       in_data, out_sample;
   logic [DEPTH*WIDTH-1:0] out_window;
   logic [FW-1:0]          out_fill;

   beat_t                  q [$];
   logic [WIDTH-1:0]       m [DEPTH];
   int unsigned            m_fill;
   int                     errors = 0;
   int                     checks = 0;

   always #5 clk = ~clk;

   ma_window_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_i      (clear),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_window_o (out_window),
      .out_sample_o (out_sample),
      .out_fill_o   (out_fill)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_fill = 0;
      for (int i = 0; i < int'(DEPTH); i++) m[i] = '0;
   endtask

   // Checks at the falling edge, updates the model, then advances past the next rising edge.
   task automatic tick();
      logic          exp_ready;
      beat_t         b;
      int unsigned   nf;
      @(negedge clk);
      exp_ready = !rst && !clear && (q.size() == 0 || out_ready);
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("out_window", out_window, q[0].win);
         chk("out_sample", out_sample, q[0].smp);
         chk("out_fill", out_fill, q[0].fill);
      end
      if (rst || clear) begin
         model_reset();
      end else begin
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (in_valid && exp_ready) begin
            nf = (m_fill == DEPTH) ? m_fill : m_fill + 1;
            for (int i = 0; i < int'(DEPTH); i++)
               b.win[(int'(DEPTH) - 1 - i) * int'(WIDTH) +: WIDTH] = m[i];
            b.smp  = in_data;
            b.fill = FW'(nf);
`ifdef MA_WARMUP_GATE_EN
            if (nf == DEPTH) q.push_back(b);
`else
            q.push_back(b);
`endif
            for (int i = int'(DEPTH) - 1; i > 0; i--) m[i] = m[i-1];
            m[0]   = in_data;
            m_fill = nf;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      in_valid = 1'b1;
      in_data  = v[WIDTH-1:0];
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      tick();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, out_valid, 1'b0);
      chk({tag, "_window"}, out_window, '0);
      chk({tag, "_sample"}, out_sample, '0);
      chk({tag, "_fill"}, out_fill, '0);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b1; in_data = 8'd77; out_ready = 1'b1;
      model_reset();
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk_zero("reset");

      // Basic stream including extremes of the signed range.
      send(5); send(-3); send(7); send(127); send(-128);
      idle();

      // Backpressure: held sample 9 must wait, then be taken the cycle out_ready returns.
      send(11);
      out_ready = 1'b0;
      send(9); send(9); send(9);
      out_ready = 1'b1;
      send(9);
      idle();

      // Clear while holding a beat; 42 must not be taken.
      send(20);
      out_ready = 1'b0; clear = 1'b1;
      send(42);
      clear = 1'b0; out_ready = 1'b1;
      idle();
      chk("clear_fill", out_fill, '0);
      send(1);
      idle();

      // Reset mid-stream with a sample offered.
      send(2); send(3);
      rst = 1'b1;
      send(99);
      rst = 1'b0;
      in_valid = 1'b0;
      chk_zero("midrst");
      send(4);
      idle();

      // Warm-up sequence from an empty window, then sign extremes.
      clear = 1'b1;
      idle();
      clear = 1'b0;
      send(1); send(2); send(3); send(4); send(5);
      send(-128); send(127);
      idle(); idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ma_window_feeder.md
Name: ma_window_feeder

Overview:
- Upstream stage of the 4-tap moving-average datapath; turns a valid/ready stream of signed 8-bit samples into the averager's per-step input: the current 4-sample window plus the newly arriving sample.
- Keeps the window in its own shift register and emits one registered output beat per accepted sample.
- Absorbs downstream backpressure with a one-deep output register.

Parameters:
- DEPTH, 4, number of samples in the window (the averager is built for 4; other values are for bench use only).
- WIDTH, 8, sample width in bits; two's-complement signed.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous flush of window and pending output.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  feeder can accept a sample this cycle.
- in_data  in  WIDTH  signed input sample.
- out_valid  out  1  output beat valid.
- out_ready  in  1  averager accepts beat.
- out_window  out  DEPTH*WIDTH  window before insertion; element 0 (newest) in MSBs, element DEPTH-1 (oldest) in LSBs.
- out_sample  out  WIDTH  sample accepted with this beat.
- out_fill  out  $clog2(DEPTH+1)  samples in window after this beat, saturating at DEPTH.

Behaviour:
- Reset (rst=1, sampled on clk):
  - window elements = 0, fill = 0.
  - out_valid = 0, out_window = 0, out_sample = 0, out_fill = 0.
  - in_ready is low during the reset cycle.
- Handshake:
  - in_ready = !rst && !clear && (!out_valid || out_ready); combinational, no combinational path from in_valid.
  - Accept = in_valid && in_ready.
  - Output beat completes when out_valid && out_ready.
  - out_* are stable while out_valid=1 and out_ready=0.
- On accept, at the next edge:
  - out_window <= current window; out_sample <= in_data; out_valid <= 1.
  - window[0] <= in_data; window[i] <= window[i-1] for i = 1..DEPTH-1. The oldest element drops out.
  - fill <= min(fill+1, DEPTH); out_fill <= that new value.
- Latency: 1 cycle from accept to out_valid.
- Throughput: one sample per cycle with out_ready held high.
- No accept while out_valid=1 and out_ready=1: out_valid <= 0 at the next edge.
- Simultaneous completion and accept: the new beat replaces the old one with no bubble.
- Clear:
  - Takes priority over accept; any sample presented that cycle is not taken (in_ready=0).
  - At the next edge: window = 0, fill = 0, out_valid = 0; a pending beat is dropped.
- No arithmetic is performed; samples pass bit-exact. Sign is preserved only by the consumer's interpretation.
- States: EMPTY (out_valid=0) and HOLD (out_valid=1). Transitions:
  - EMPTY -> HOLD on accept.
  - HOLD -> EMPTY on completion without accept.
  - HOLD -> HOLD on stall, or on completion with accept.
  - Any state -> EMPTY on rst or clear.

Optional Feature:
- MA_WARMUP_GATE_EN defined:
  - An accepted sample produces an output beat only when the new fill count is DEPTH.
  - The first DEPTH-1 samples after reset or clear shift into the window silently; out_valid stays 0 and in_ready = !rst && !clear.
- Undefined: every accepted sample produces a beat, including warm-up beats whose window contains reset zeros; out_fill lets the consumer tell them apart.

Test Plan:
- Reset then stream 5,-3,7,127,-128 with out_ready=1 → beats:
  - ({0,0,0,0},5,fill1)
  - ({5,0,0,0},-3,fill2)
  - ({-3,5,0,0},7,fill3)
  - ({7,-3,5,0},127,fill4)
  - ({127,7,-3,5},-128,fill4)
  - Each beat 1 cycle after its accept.
- Backpressure: out_ready=0 for 3 cycles after the first beat, in_valid held with 9 → in_ready=0; out_window/out_sample stay constant. out_ready rises → 9 accepted in that same cycle; beat {9,...} appears next cycle with no bubble.
- Clear while HOLD with in_valid=1, data 42 → 42 not accepted. Next cycle out_valid=0 and fill=0. The next sample 1 yields ({0,0,0,0},1,fill1).
- rst asserted mid-stream for one cycle with in_valid=1 → no accept; all outputs 0 next cycle; the subsequent window starts from zeros.
- MA_WARMUP_GATE_EN defined, stream 1,2,3,4,5 → out_valid first on sample 4 with ({3,2,1,0},4,fill4); sample 5 gives ({4,3,2,1},5,fill4).
- Sign/extremes: -128 followed by 127 → bit patterns 0x80 and 0x7F pass unchanged in out_window/out_sample.
